cpu_wb_rf: RTL

CPU_WB_RF -- requirements
Module: cpu_wb_rf

---
 rtl/cpu_wb_rf.sv | 115 +++++++++++
 1 files changed

// File: rtl/cpu_wb_rf.sv
// Writeback stage with a 2-entry in-order commit buffer in front of a small register file.
// Reads forward from the youngest buffered write, so younger results are visible before they commit.
module cpu_wb_rf #(
    parameter int NREGS   = 4,
    parameter int XLEN    = 8,
    parameter int ZERO_R0 = 0,
    localparam int IDXW   = ($clog2(NREGS) < 1) ? 1 : $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_we,
    input  logic [IDXW-1:0]       in_idx,
    input  logic [XLEN-1:0]       in_val,
    input  logic                  hold,
    input  logic                  flush,
    input  logic [IDXW-1:0]       rd_idx0,
    input  logic [IDXW-1:0]       rd_idx1,
    output logic [XLEN-1:0]       rd_val0,
    output logic [XLEN-1:0]       rd_val1,
    output logic [NREGS*XLEN-1:0] regs_out,
    output logic [1:0]            pending,
    output logic [31:0]           retired
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

    typedef struct packed {
        logic            we;
        logic [IDXW-1:0] idx;
        logic [XLEN-1:0] val;
    } ent_t;

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    ent_t [1:0]                 buf_q, buf_d;
    occ_t                       occ_q, occ_d;
    logic [31:0]                retired_q, retired_d;
    logic                       accept, commit;
    logic [1:0]                 cnt;

    // An index names a writable/readable register unless it is out of range or a hardwired r0.
    function automatic logic idx_ok(input logic [IDXW-1:0] idx);
        idx_ok = (32'(idx) < 32'(NREGS)) && !((ZERO_R0 != 0) && (idx == '0));
    endfunction

    assign in_ready = !rst && (occ_q != FULL);
    assign accept   = in_valid && in_ready;
    assign commit   = (occ_q != EMPTY) && !hold;

    always_comb begin
        regs_d    = regs_q;
        buf_d     = buf_q;
        occ_d     = occ_q;
        retired_d = retired_q;
        cnt       = occ_q;
        if (!flush) begin
            if (commit) begin
                if (buf_q[0].we && idx_ok(buf_q[0].idx))
                    regs_d[buf_q[0].idx] = buf_q[0].val;
                buf_d[0]  = buf_q[1];
                retired_d = retired_q + 32'd1;
                cnt       = cnt - 2'd1;
            end
            // Tail slot is computed after the pop so push+pop keeps occupancy and order.
            if (accept) begin
                buf_d[cnt[0]] = '{we: in_we, idx: in_idx, val: in_val};
                cnt           = cnt + 2'd1;
            end
            occ_d = occ_t'(cnt);
        end else begin
            occ_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q    <= '0;
            buf_q     <= '0;
            occ_q     <= EMPTY;
            retired_q <= '0;
        end else begin
            regs_q    <= regs_d;
            buf_q     <= buf_d;
            occ_q     <= occ_d;
            retired_q <= retired_d;
        end
    end

    logic [1:0][IDXW-1:0] ridx;
    logic [1:0][XLEN-1:0] rval;

    assign ridx = {rd_idx1, rd_idx0};

    // Later matches override earlier ones, so slot 1 (youngest) wins over slot 0 over regs.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rval[p] = '0;
            if (idx_ok(ridx[p])) begin
                rval[p] = regs_q[ridx[p]];
                if (occ_q != EMPTY && buf_q[0].we && buf_q[0].idx == ridx[p])
                    rval[p] = buf_q[0].val;
                if (occ_q == FULL && buf_q[1].we && buf_q[1].idx == ridx[p])
                    rval[p] = buf_q[1].val;
            end
        end
    end

    assign rd_val0  = rval[0];
    assign rd_val1  = rval[1];
    assign regs_out = regs_q;
    assign pending  = occ_q;
    assign retired  = retired_q;

endmodule
